// File: rtl/state_sync_filt_if.sv
// State-word crossing bundle: source word in, filtered word and
// change/valid flags out on the VGA side.
interface state_sync_filt_if #(
  parameter int BITS = 1
);
  logic [BITS-1:0] state_50;
  logic [BITS-1:0] state_vga;
  logic            state_changed;
  logic            state_valid;

  modport master (
    output state_50,
    input  state_vga,
    input  state_changed,
    input  state_valid
  );

  modport slave (
    input  state_50,
    output state_vga,
    output state_changed,
    output state_valid
  );
endinterface

// File: rtl/state_sync_filt.sv
// CLOCK_50 -> VGA_CLK state-word synchroniser with stability filter,
// change strobe and valid flag.
module state_sync_filt #(
  parameter int              BITS          = 1,
  parameter int              STAGES        = 2,
  parameter int              STABLE_CYCLES = 2,
  parameter logic [BITS-1:0] RESET_VALUE   = '0
) (
  input  logic             clk_vga,
  input  logic             rst_n,
  state_sync_filt_if.slave bus
);

  localparam int CW = $clog2(STABLE_CYCLES) + 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES - 1);

  generate
    if (STAGES < 2 || STABLE_CYCLES < 1) begin : g_bad_params
      $error("state_sync_filt: STAGES must be >= 2, STABLE_CYCLES >= 1");
    end
  endgenerate

  (* SYNCHRONIZER_IDENTIFICATION = "FORCED" *)
  logic [BITS-1:0] sync [STAGES];

  logic [BITS-1:0] tail;
  logic [BITS-1:0] cand;
  logic [CW-1:0]   cnt;
  logic [BITS-1:0] state_q;
  logic            changed_q;
  logic            valid_q;

  // Plain flop chain; nothing may sit between these stages.
  always_ff @(posedge clk_vga or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < STAGES; i++) begin
        sync[i] <= RESET_VALUE;
      end
    end else begin
      sync[0] <= bus.state_50;
      for (int i = 1; i < STAGES; i++) begin
        sync[i] <= sync[i-1];
      end
    end
  end

  assign tail = sync[STAGES-1];

  // cnt saturates at CNT_MAX, so a held word keeps re-qualifying
  // without wrapping; only a commit of a new value pulses.
  always_ff @(posedge clk_vga or negedge rst_n) begin
    if (!rst_n) begin
      cand      <= RESET_VALUE;
      cnt       <= '0;
      state_q   <= RESET_VALUE;
      changed_q <= 1'b0;
      valid_q   <= 1'b0;
    end else begin
      changed_q <= 1'b0;
      if (tail != cand) begin
        cand <= tail;
        cnt  <= '0;
      end else if (cnt == CNT_MAX) begin
        valid_q <= 1'b1;
        if (cand != state_q) begin
          state_q   <= cand;
          changed_q <= 1'b1;
        end
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  assign bus.state_vga     = state_q;
  assign bus.state_changed = changed_q;
  assign bus.state_valid   = valid_q;

endmodule
